// File: rtl/instruction_fetch_pkg.sv
// Shared RV32I definitions used by the fetch stage: reset vector, NOP encoding
// and the fetch state type.
package instruction_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_WORD     = 32'h0000_0013;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the PC, drives the registered-read instruction memory,
// presents fetched words to decode, and supports stall, redirect and debug halt.
//
// state   | meaning
// ST_RUN  | issuing one fetch per cycle (or re-reading the held word under stall)
// ST_HALT | parked for the debugger; no memory reads, pc_q is the resume address
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_VECTOR,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            debug_halt,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_read_en,
  input  logic [XLEN-1:0] imem_data,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_valid,
  output logic            if_fault,
  output logic            halted,
  output logic [XLEN-1:0] debug_pc
);

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] resp_pc_q;
  logic            resp_valid_q;
  logic            resp_fault_q;
  logic [XLEN-1:0] target_pc;
  logic            running;
  logic            hold_resp;

  assign target_pc = word_align(redirect_pc);
  assign running   = (state_q == ST_RUN);
  assign hold_resp = running && stall && resp_valid_q;

  always_comb begin
    imem_addr    = pc_q;
    imem_read_en = 1'b1;
    if (!reset) begin
      imem_addr = RESET_PC;
    end else if (redirect_valid) begin
      imem_addr    = target_pc;
      imem_read_en = running && !debug_halt;
    end else if (debug_halt) begin
      imem_read_en = 1'b0;
    end else if (hold_resp) begin
      // re-read the held word so the memory's output register keeps it
      imem_addr = resp_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      resp_pc_q    <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
    end else if (redirect_valid) begin
      if (running && !debug_halt) begin
        resp_pc_q    <= target_pc;
        resp_valid_q <= 1'b1;
        resp_fault_q <= |redirect_pc[1:0];
        pc_q         <= target_pc + 32'd4;
      end else begin
        // debugger is setting the resume PC; nothing is presented to decode
        pc_q         <= target_pc;
        resp_valid_q <= 1'b0;
        state_q      <= ST_HALT;
      end
    end else if (debug_halt) begin
      if (running) begin
        state_q      <= ST_HALT;
        resp_valid_q <= 1'b0;
        if (stall && resp_valid_q) begin
          pc_q <= resp_pc_q;
        end
      end
    end else if (!hold_resp) begin
      state_q      <= ST_RUN;
      resp_pc_q    <= pc_q;
      resp_valid_q <= 1'b1;
      resp_fault_q <= 1'b0;
      pc_q         <= pc_q + 32'd4;
    end
  end

  assign if_pc    = resp_pc_q;
  assign if_valid = resp_valid_q;
  assign if_fault = resp_fault_q;
  assign if_instr = resp_fault_q ? NOP_INSTR : imem_data;
  assign halted   = (state_q == ST_HALT);
  assign debug_pc = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed walk through the fetch scenarios, then
// randomized stall/redirect/halt/reset traffic against a transaction-level model.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        debug_halt;
  logic [31:0] imem_addr;
  logic        imem_read_en;
  logic [31:0] imem_data;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        if_fault;
  logic        halted;
  logic [31:0] debug_pc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .debug_halt     (debug_halt),
    .imem_addr      (imem_addr),
    .imem_read_en   (imem_read_en),
    .imem_data      (imem_data),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_valid       (if_valid),
    .if_fault       (if_fault),
    .halted         (halted),
    .debug_pc       (debug_pc)
  );

  // registered-read instruction memory, 64 words aliased over the address space
  always @(posedge clk) begin
    if (imem_read_en) imem_data <= mem[imem_addr[7:2]];
  end

  // Reference model: the word presented to decode and the address to fetch next
  logic [31:0] m_next;
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_fault;
  logic        m_parked;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic stl, input logic rv,
                            input logic [31:0] rp, input logic dh);
    logic [31:0] tgt;
    tgt = rp & 32'hFFFF_FFFC;
    if (!rst) begin
      m_next = 32'h0; m_pc = 32'h0; m_valid = 1'b0; m_fault = 1'b0; m_parked = 1'b0;
    end else if (rv && !m_parked && !dh) begin
      m_pc = tgt; m_valid = 1'b1; m_fault = (rp[1:0] != 2'b00); m_next = tgt + 32'd4;
    end else if (rv) begin
      m_next = tgt; m_valid = 1'b0; m_parked = 1'b1;
    end else if (dh) begin
      if (!m_parked) begin
        // an unconsumed word must be fetched again on resume
        if (stl && m_valid) m_next = m_pc;
        m_valid = 1'b0;
        m_parked = 1'b1;
      end
    end else if (!(m_parked == 1'b0 && stl && m_valid)) begin
      m_pc = m_next; m_valid = 1'b1; m_fault = 1'b0; m_next = m_next + 32'd4;
      m_parked = 1'b0;
    end
  endtask

  // One cycle: drive at negedge, check combinational fetch port, clock, check outputs.
  task automatic step(input logic rst, input logic stl, input logic rv,
                      input logic [31:0] rp, input logic dh);
    logic        exp_re;
    logic [31:0] exp_addr;
    reset = rst; stall = stl; redirect_valid = rv; redirect_pc = rp; debug_halt = dh;
    #1;
    if (!rst)      begin exp_re = 1'b1; exp_addr = 32'h0; end
    else if (rv)   begin exp_re = !m_parked && !dh; exp_addr = rp & 32'hFFFF_FFFC; end
    else if (dh)   begin exp_re = 1'b0; exp_addr = 32'h0; end
    else if (!m_parked && stl && m_valid) begin exp_re = 1'b1; exp_addr = m_pc; end
    else           begin exp_re = 1'b1; exp_addr = m_next; end
    check_eq("imem_read_en", {31'b0, imem_read_en}, {31'b0, exp_re});
    if (exp_re || rv) check_eq("imem_addr", imem_addr, exp_addr);
    @(posedge clk);
    model_edge(rst, stl, rv, rp, dh);
    #1;
    check_eq("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    check_eq("halted", {31'b0, halted}, {31'b0, m_parked});
    check_eq("debug_pc", debug_pc, m_next);
    if (m_valid) begin
      check_eq("if_pc", if_pc, m_pc);
      check_eq("if_fault", {31'b0, if_fault}, {31'b0, m_fault});
      check_eq("if_instr", if_instr, m_fault ? NOP : mem[m_pc[7:2]]);
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0100 + i;
    m_next = 32'h0; m_pc = 32'h0; m_valid = 1'b0; m_fault = 1'b0; m_parked = 1'b0;
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; debug_halt = 1'b0;
    @(negedge clk);

    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("reset_valid", {31'b0, if_valid}, 32'h0);
    check_eq("reset_debug_pc", debug_pc, 32'h0);

    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("first_pc", if_pc, 32'h0);
    check_eq("first_instr", if_instr, 32'h100);
    run(2);
    check_eq("third_instr", if_instr, 32'h102);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check_eq("stall_pc", if_pc, 32'h8);
    check_eq("stall_instr", if_instr, 32'h102);
    run(1);
    check_eq("after_stall", if_instr, 32'h103);

    step(1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
    check_eq("redir_instr", if_instr, 32'h110);
    run(1);
    check_eq("redir_next", if_pc, 32'h44);

    step(1'b1, 1'b0, 1'b1, 32'h42, 1'b0);
    check_eq("mis_fault", {31'b0, if_fault}, 32'h1);
    check_eq("mis_instr", if_instr, NOP);
    run(1);
    check_eq("mis_next_fault", {31'b0, if_fault}, 32'h0);

    step(1'b1, 1'b0, 1'b1, 32'h0C, 1'b0);
    run(1);
    check_eq("pre_halt_pc", if_pc, 32'h10);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check_eq("halt_flag", {31'b0, halted}, 32'h1);
    check_eq("halt_debug_pc", debug_pc, 32'h10);
    mem[4] = 32'hCAFE_BABE;
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("resume_pc", if_pc, 32'h10);
    check_eq("resume_instr", if_instr, 32'hCAFE_BABE);

    step(1'b1, 1'b0, 1'b1, 32'h20, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("midreset_valid", {31'b0, if_valid}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("refetch_pc", if_pc, 32'h0);

    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run(1);
    check_eq("wrap_pc", if_pc, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic        r_rst, r_stl, r_rv, r_dh;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(0, 99) >= 2);
      r_stl = ($urandom_range(0, 99) < 30);
      r_rv  = ($urandom_range(0, 99) < 10);
      r_dh  = m_parked ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 8);
      r_pc  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_00FF);
      if (m_parked && r_dh && $urandom_range(0, 9) == 0) mem[$urandom_range(0, 63)] = $urandom;
      step(r_rst, r_stl, r_rv, r_pc, r_dh);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
